comp_sort_ctrl: RTL and testbench
=================================

Name: comp_sort_ctrl

Overview:
Sequential sort engine that shares one four_bit_comp instance across a buffered batch of 4-bit values. It accepts a batch over a valid/ready input stream and bubble-sorts it in place, one comparison per clock. It then streams the sorted batch out over a valid/ready output. It sits between a producer and a consumer of 4-bit samples and is the first block to schedule comparator use over time.

Parameters:
DEPTH, 8, maximum batch size in entries; legal range 2..16.
DESCEND, 0, 0 = ascending output order, 1 = descending.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer has a value on in_data
in_ready  output  1  block accepts a value this cycle
in_data  input  4  unsigned value to load
in_last  input  1  qualifies in_data as the final value of the batch
out_valid  output  1  out_data holds a sorted value
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  4  sorted value
out_last  output  1  qualifies out_data as the final value of the batch
busy  output  1  high in SORT and DRAIN
cmp_count  output  8  comparisons issued for the current batch; saturates at 255

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state = LOAD, in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
  - cmp_count = 0; entry count n = 0; all pointers = 0.
  - Buffer contents are don't-care after reset.
- Reset mid-operation (any state): the batch is abandoned and the block returns to LOAD with the reset values next cycle.
- LOAD state:
  - in_ready = 1.
  - On in_valid && in_ready: write in_data to mem[n], then n <= n+1.
  - If the accepted beat has in_last = 1, or n+1 == DEPTH, leave LOAD.
    - If the batch size is 1, go to DRAIN.
    - Otherwise go to SORT with pass p = 0, index i = 0, swap flag = 0, cmp_count = 0.
  - An empty batch is impossible; the state changes only on an accepted beat.
  - in_last arriving exactly on the DEPTH-th beat is legal.
- SORT state:
  - in_ready = 0.
  - Comparator inputs are a = mem[i], b = mem[i+1], driven combinationally from the buffer.
  - Swap condition: greater when DESCEND = 0, less when DESCEND = 1.
  - Equal values never swap, so the sort is stable.
  - On swap: exchange mem[i] and mem[i+1] in the same cycle and set the swap flag.
  - Every SORT cycle increments cmp_count, saturating at 255.
  - If i < n-2-p: i <= i+1.
  - Otherwise the pass ends:
    - If the swap flag is clear, or p == n-2, go to DRAIN.
    - Else p <= p+1, i <= 0, swap flag <= 0.
  - Cycle bounds: best case (already sorted) n-1 cycles; worst case n(n-1)/2 cycles.
- DRAIN state:
  - out_valid = 1, out_data = mem[rd], out_last = (rd == n-1).
  - On out_valid && out_ready: rd <= rd+1.
  - When the last beat is accepted: n <= 0, rd <= 0, go to LOAD; out_valid drops the next cycle.
  - out_data and out_last stay stable while out_ready = 0.
  - in_ready remains 0 until the state is back in LOAD.
- Latency: from the accepted in_last beat to the first out_valid is 1 + (number of SORT cycles).
- Widths: values are unsigned 4-bit. Pointers are clog2(DEPTH)+1 bits wide so that n == DEPTH is representable.

Decomposition:
- Shared package holds:
  - state encoding: LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2
  - DATA_W = 4
  - CMP_CNT_W = 8
- Sub-module: the existing four_bit_comp, instantiated once as the shared comparator. All sequencing, storage and handshakes live in comp_sort_ctrl.

Test Plan:
- Reset then load 8 values {9,3,15,0,7,7,1,12} with in_last on the 8th -> output 0,1,3,7,7,9,12,15 with out_last on 15; cmp_count <= 28.
- Already sorted batch {1,2,3,4} -> exactly 3 SORT cycles; cmp_count = 3; output 1,2,3,4.
- Single-value batch {5} with in_last -> no SORT cycles; one output 5 with out_last = 1; cmp_count = 0.
- DESCEND = 1, batch {2,14,2,8} -> output 14,8,2,2; hold out_ready = 0 for 5 cycles mid-drain -> out_data stable, no beat lost.
- 9 beats without in_last at DEPTH = 8 -> SORT starts after beat 8 and in_ready = 0 for beat 9. Beat 9 is accepted in the next LOAD after drain completes.
- Assert rst for one cycle during SORT of {4,3,2,1} -> next cycle in LOAD with in_ready = 1, out_valid = 0, cmp_count = 0. A fresh batch {6,5} then sorts to 5,6.

Source files
------------

// File: rtl/comp_sort_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | comp_sort_ctrl_pkg : shared types and widths for the sorter  |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
package comp_sort_ctrl_pkg;

   localparam int DATA_W    = 4;
   localparam int CMP_CNT_W = 8;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/comp_sort_ctrl_four_bit_comp.sv
`default_nettype none
// +--------------------------------------------------------------+
// | four_bit_comp : unsigned 4-bit magnitude comparator          |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module four_bit_comp (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       gt,
   output logic       lt,
   output logic       eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/comp_sort_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | comp_sort_ctrl : buffered batch bubble sort, one compare/clk |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module comp_sort_ctrl
   import comp_sort_ctrl_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter bit DESCEND = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic [CMP_CNT_W-1:0] cmp_count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_pw = c_aw + 1;

   localparam logic [c_pw-1:0]      c_depth   = c_pw'(DEPTH);
   localparam logic [c_pw-1:0]      c_one_p   = c_pw'(1);
   localparam logic [c_pw-1:0]      c_two_p   = c_pw'(2);
   localparam logic [c_aw-1:0]      c_one_a   = c_aw'(1);
   localparam logic [CMP_CNT_W-1:0] c_cnt_one = CMP_CNT_W'(1);
   localparam logic [CMP_CNT_W-1:0] c_cnt_max = '1;

   state_t               r_state;
   logic [DATA_W-1:0]    r_mem [DEPTH];
   logic [c_pw-1:0]      r_n;
   logic [c_pw-1:0]      r_i;
   logic [c_pw-1:0]      r_p;
   logic [c_pw-1:0]      r_rd;
   logic                 r_swapped;
   logic [CMP_CNT_W-1:0] r_cmp_count;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [DATA_W-1:0]    r_out_data;
   logic                 r_busy;

   logic [c_aw-1:0]      w_ia;
   logic [c_aw-1:0]      w_ib;
   logic [DATA_W-1:0]    w_a;
   logic [DATA_W-1:0]    w_b;
   logic                 w_gt;
   logic                 w_lt;
   logic                 w_eq;
   logic                 w_swap;
   logic [c_pw-1:0]      w_pass_lim;
   logic                 w_pass_end;
   logic                 w_sorted;
   logic [c_pw-1:0]      w_n_inc;
   logic [c_pw-1:0]      w_n_dec;
   logic [c_pw-1:0]      w_rd_next;
   logic [DATA_W-1:0]    w_head;

   assign w_ia = r_i[c_aw-1:0];
   assign w_ib = w_ia + c_one_a;
   assign w_a  = r_mem[w_ia];
   assign w_b  = r_mem[w_ib];

   four_bit_comp u_cmp (
      .a  (w_a),
      .b  (w_b),
      .gt (w_gt),
      .lt (w_lt),
      .eq (w_eq)
   );

   // Equal keys never swap, which keeps the sort stable.
   assign w_swap     = !w_eq && (DESCEND ? w_lt : w_gt);
   assign w_pass_lim = r_n - c_two_p - r_p;
   assign w_pass_end = !(r_i < w_pass_lim);
   // A swap on the final compare of a pass still forces another pass.
   assign w_sorted   = !(r_swapped || w_swap) || (r_p == r_n - c_two_p);
   assign w_n_inc    = r_n + c_one_p;
   assign w_n_dec    = r_n - c_one_p;
   assign w_rd_next  = r_rd + c_one_p;
   // Head entry as it will be after this cycle's possible swap at index 0.
   assign w_head     = (w_ia == '0 && w_swap) ? w_b : r_mem[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= LOAD;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
         r_cmp_count <= '0;
         r_n         <= '0;
         r_i         <= '0;
         r_p         <= '0;
         r_rd        <= '0;
         r_swapped   <= 1'b0;
      end else begin
         unique case (r_state)
            LOAD: begin
               if (in_valid) begin
                  r_mem[r_n[c_aw-1:0]] <= in_data;
                  r_n                  <= w_n_inc;
                  if (in_last || w_n_inc == c_depth) begin
                     r_in_ready  <= 1'b0;
                     r_busy      <= 1'b1;
                     r_cmp_count <= '0;
                     r_rd        <= '0;
                     if (r_n == '0) begin
                        r_state     <= DRAIN;
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_data;
                        r_out_last  <= 1'b1;
                     end else begin
                        r_state   <= SORT;
                        r_p       <= '0;
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                     end
                  end
               end
            end
            SORT: begin
               if (w_swap) begin
                  r_mem[w_ia] <= w_b;
                  r_mem[w_ib] <= w_a;
               end
               if (r_cmp_count != c_cnt_max) begin
                  r_cmp_count <= r_cmp_count + c_cnt_one;
               end
               if (!w_pass_end) begin
                  r_i       <= r_i + c_one_p;
                  r_swapped <= r_swapped | w_swap;
               end else if (w_sorted) begin
                  r_state     <= DRAIN;
                  r_rd        <= '0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_head;
                  r_out_last  <= 1'b0;
               end else begin
                  r_p       <= r_p + c_one_p;
                  r_i       <= '0;
                  r_swapped <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (r_out_last) begin
                     r_state     <= LOAD;
                     r_n         <= '0;
                     r_rd        <= '0;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_data  <= '0;
                     r_in_ready  <= 1'b1;
                     r_busy      <= 1'b0;
                  end else begin
                     r_rd       <= w_rd_next;
                     r_out_data <= r_mem[w_rd_next[c_aw-1:0]];
                     r_out_last <= (w_rd_next == w_n_dec);
                  end
               end
            end
            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign cmp_count = r_cmp_count;

endmodule
`default_nettype wire

// File: tb/tb_comp_sort_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_comp_sort_ctrl : ascending and descending sorter bench    |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_comp_sort_ctrl;

   localparam int DEPTH = 8;

   logic            clk;
   logic [1:0]      rst;
   logic [1:0]      in_valid;
   logic [1:0]      in_ready;
   logic [1:0][3:0] in_data;
   logic [1:0]      in_last;
   logic [1:0]      out_valid;
   logic [1:0]      out_ready;
   logic [1:0][3:0] out_data;
   logic [1:0]      out_last;
   logic [1:0]      busy;
   logic [1:0][7:0] cmp_count;

   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode [2] = '{0, 0};

   // Behavioural model state: 0 loading, 1 sorting, 2 draining.
   int m_mode [2]   = '{0, 0};
   int m_n    [2]   = '{0, 0};
   int m_rd   [2]   = '{0, 0};
   int m_cnt  [2]   = '{0, 0};
   int m_left [2]   = '{0, 0};
   int m_vals [2][16];
   int m_sorted [2][16];

   int cap_n    [2] = '{0, 0};
   int cap_data [2][64];
   int cap_last [2][64];
   int cap_cmp  [2][64];
   int eb       [2] = '{0, 0};

   comp_sort_ctrl #(.DEPTH(DEPTH), .DESCEND(1'b0)) u_asc (
      .clk(clk), .rst(rst[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
      .busy(busy[0]), .cmp_count(cmp_count[0])
   );

   comp_sort_ctrl #(.DEPTH(DEPTH), .DESCEND(1'b1)) u_desc (
      .clk(clk), .rst(rst[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
      .busy(busy[1]), .cmp_count(cmp_count[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, d, act, exp, $time);
      end
   endtask

   // Expected order via stable insertion sort; expected compare count via
   // bubble passes that stop after a pass without exchanges.
   task automatic model_batch(input int d);
      int a [16];
      int s [16];
      int n, v, j, t, cnt;
      bit desc, sw;
      n    = m_n[d];
      desc = (d == 1);
      for (int k = 0; k < n; k++) a[k] = m_vals[d][k];
      for (int k = 0; k < n; k++) begin
         v = a[k];
         j = k;
         while (j > 0 && (desc ? (v > s[j-1]) : (v < s[j-1]))) begin
            s[j] = s[j-1];
            j--;
         end
         s[j] = v;
      end
      for (int k = 0; k < n; k++) m_sorted[d][k] = s[k];
      cnt = 0;
      for (int p = 0; p <= n - 2; p++) begin
         sw = 1'b0;
         for (int i = 0; i < n - 1 - p; i++) begin
            cnt++;
            if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
               t = a[i]; a[i] = a[i+1]; a[i+1] = t;
               sw = 1'b1;
            end
         end
         if (!sw) break;
      end
      m_left[d] = cnt;
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk("in_ready",  d, in_ready[d],  m_mode[d] == 0);
         chk("out_valid", d, out_valid[d], m_mode[d] == 2);
         chk("busy",      d, busy[d],      m_mode[d] != 0);
         chk("cmp_count", d, cmp_count[d], m_cnt[d]);
         if (m_mode[d] == 2) begin
            chk("out_data", d, out_data[d], m_sorted[d][m_rd[d]]);
            chk("out_last", d, out_last[d], m_rd[d] == m_n[d] - 1);
            if (out_ready[d]) begin
               if (cap_n[d] < 64) begin
                  cap_data[d][cap_n[d]] = out_data[d];
                  cap_last[d][cap_n[d]] = out_last[d];
                  cap_cmp[d][cap_n[d]]  = cmp_count[d];
               end
               cap_n[d]++;
            end
         end
         if (rst[d]) begin
            m_mode[d] = 0; m_n[d] = 0; m_rd[d] = 0; m_cnt[d] = 0;
         end else begin
            case (m_mode[d])
               0: if (in_valid[d]) begin
                  m_vals[d][m_n[d]] = in_data[d];
                  m_n[d]++;
                  if (in_last[d] || m_n[d] == DEPTH) begin
                     model_batch(d);
                     m_cnt[d]  = 0;
                     m_rd[d]   = 0;
                     m_mode[d] = (m_n[d] == 1) ? 2 : 1;
                  end
               end
               1: begin
                  m_cnt[d] = (m_cnt[d] < 255) ? m_cnt[d] + 1 : 255;
                  m_left[d]--;
                  if (m_left[d] == 0) m_mode[d] = 2;
               end
               default: if (out_ready[d]) begin
                  if (m_rd[d] == m_n[d] - 1) begin
                     m_mode[d] = 0; m_n[d] = 0; m_rd[d] = 0;
                  end else begin
                     m_rd[d]++;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      out_ready = 2'b11;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            case (rdy_mode[d])
               0:       out_ready[d] = 1'b1;
               1:       out_ready[d] = ($urandom_range(0, 2) != 0);
               default: out_ready[d] = 1'b0;
            endcase
         end
      end
   end

   // Values are packed as nibbles, entry k at bits [4k+3:4k].
   task automatic send_batch(input int d, input int n, input logic [63:0] vals, input bit last);
      for (int k = 0; k < n; k++) begin
         bit acc;
         int guard;
         in_valid[d] = 1'b1;
         in_data[d]  = vals[4*k +: 4];
         in_last[d]  = last && (k == n - 1);
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 500) begin
            @(negedge clk);
            acc = in_ready[d];
            @(posedge clk);
            #1;
            guard++;
         end
         if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout dut%0d actual=not-accepted required=accepted", d);
         end
      end
      in_valid[d] = 1'b0;
      in_last[d]  = 1'b0;
   endtask

   task automatic expect_batch(input int d, input int n, input logic [63:0] vals, input int exp_cmp);
      int guard;
      guard = 0;
      while (cap_n[d] < eb[d] + n && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_done", d, cap_n[d] >= eb[d] + n, 1);
      for (int k = 0; k < n; k++) begin
         chk("lit_data", d, cap_data[d][eb[d]+k], vals[4*k +: 4]);
         chk("lit_last", d, cap_last[d][eb[d]+k], k == n - 1);
      end
      chk("lit_cmp", d, cap_cmp[d][eb[d]], exp_cmp);
      eb[d] += n;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] held;
      bit acc [2];
      rst      = 2'b11;
      in_valid = '0;
      in_data  = '0;
      in_last  = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready",  d, in_ready[d],  1);
         chk("rst_out_valid", d, out_valid[d], 0);
         chk("rst_out_last",  d, out_last[d],  0);
         chk("rst_out_data",  d, out_data[d],  0);
         chk("rst_busy",      d, busy[d],      0);
         chk("rst_cmp",       d, cmp_count[d], 0);
      end
      rst = 2'b00;

      send_batch(0, 8, 64'hC1770F39, 1'b1);
      expect_batch(0, 8, 64'hFC977310, 27);

      send_batch(0, 4, 64'h4321, 1'b1);
      expect_batch(0, 4, 64'h4321, 3);

      send_batch(0, 1, 64'h5, 1'b1);
      expect_batch(0, 1, 64'h5, 0);

      // Full buffer without in_last: the ninth beat waits for the next LOAD.
      send_batch(0, 8, 64'h12345678, 1'b0);
      chk("full_in_ready", 0, in_ready[0], 0);
      chk("full_busy",     0, busy[0],     1);
      send_batch(0, 2, 64'hBA, 1'b1);
      expect_batch(0, 8, 64'h87654321, 28);
      expect_batch(0, 2, 64'hBA, 1);

      send_batch(0, 4, 64'h1234, 1'b1);
      @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      chk("midrst_in_ready",  0, in_ready[0],  1);
      chk("midrst_out_valid", 0, out_valid[0], 0);
      chk("midrst_cmp",       0, cmp_count[0], 0);
      chk("midrst_busy",      0, busy[0],      0);
      send_batch(0, 2, 64'h56, 1'b1);
      expect_batch(0, 2, 64'h65, 1);

      send_batch(1, 4, 64'h82E2, 1'b1);
      for (int g = 0; g < 500 && cap_n[1] < eb[1] + 2; g++) @(negedge clk);
      rdy_mode[1] = 2;
      @(posedge clk);
      #2;
      held = out_data[1];
      repeat (5) @(posedge clk);
      #2;
      chk("stall_valid", 1, out_valid[1], 1);
      chk("stall_data",  1, out_data[1],  held);
      rdy_mode[1] = 0;
      expect_batch(1, 4, 64'h228E, 6);

      rdy_mode[0] = 1;
      rdy_mode[1] = 1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) acc[d] = in_valid[d] && in_ready[d];
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
               rst[d] = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
               rst[d]      = 1'b1;
               in_valid[d] = 1'b0;
               in_last[d]  = 1'b0;
            end
            if (!rst[d] && (acc[d] || !in_valid[d])) begin
               if ($urandom_range(0, 9) < 7) begin
                  in_valid[d] = 1'b1;
                  in_data[d]  = 4'($urandom_range(0, 15));
                  in_last[d]  = ($urandom_range(0, 5) == 0);
               end else begin
                  in_valid[d] = 1'b0;
                  in_last[d]  = 1'b0;
               end
            end
         end
      end
      in_valid    = '0;
      in_last     = '0;
      rst         = '0;
      rdy_mode[0] = 0;
      rdy_mode[1] = 0;
      repeat (200) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
